// File: rtl/mem_load_unit.sv
// Load unit for RISC-V scalar loads (LB..LD, LBU..LWU) over a big-endian,
// 32-bit-word data memory whose read data arrives one cycle after the strobe.
module mem_load_unit #(
    parameter int ADDR_LIMIT = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_funct3,
    output logic        mem_en,
    output logic [11:0] mem_waddr,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err
);

    typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [13:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] hi_q;
    logic [63:0] data_q;
    logic        err_q;

    logic        req_err;
    logic [3:0]  req_size;
    logic [64:0] req_end;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [63:0] load_val;

    // The end-of-access sum is one bit wider so a huge address cannot wrap into range.
    always_comb begin
        req_size = 4'd1 << req_funct3[1:0];
        req_end  = {1'b0, req_addr} + {61'd0, req_size};
        case (req_funct3)
            3'b111:         req_err = 1'b1;
            3'b011:         req_err = (req_addr[2:0] != 3'd0);
            3'b010, 3'b110: req_err = (req_addr[1:0] != 2'd0);
            3'b001, 3'b101: req_err = req_addr[0];
            default:        req_err = 1'b0;
        endcase
        if (req_end > 65'(ADDR_LIMIT)) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        sel_byte = 8'(mem_rdata >> {~addr_q[1:0], 3'b000});
        sel_half = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (funct3_q)
            3'b000:  load_val = {{56{sel_byte[7]}}, sel_byte};
            3'b100:  load_val = {56'd0, sel_byte};
            3'b001:  load_val = {{48{sel_half[15]}}, sel_half};
            3'b101:  load_val = {48'd0, sel_half};
            3'b010:  load_val = {{32{mem_rdata[31]}}, mem_rdata};
            3'b110:  load_val = {32'd0, mem_rdata};
            3'b011:  load_val = {hi_q, mem_rdata};
            default: load_val = 64'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_err ? RESP : RD_HI;
            RD_HI:   state_d = (funct3_q == 3'b011) ? RD_LO : WAIT;
            RD_LO:   state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Rejected requests leave data_q cleared, so the response carries zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= 14'd0;
            funct3_q <= 3'd0;
            hi_q     <= 32'd0;
            data_q   <= 64'd0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                addr_q   <= req_addr[13:0];
                funct3_q <= req_funct3;
                err_q    <= req_err;
                data_q   <= 64'd0;
            end
            if (state_q == RD_LO) begin
                hi_q <= mem_rdata;
            end
            if (state_q == WAIT) begin
                data_q <= load_val;
            end
        end
    end

    always_comb begin
        req_ready  = 1'b0;
        mem_en     = 1'b0;
        mem_waddr  = 12'd0;
        resp_valid = 1'b0;
        resp_data  = 64'd0;
        resp_err   = 1'b0;
        case (state_q)
            IDLE: req_ready = 1'b1;
            RD_HI: begin
                mem_en    = 1'b1;
                mem_waddr = addr_q[13:2];
            end
            RD_LO: begin
                mem_en    = 1'b1;
                mem_waddr = addr_q[13:2] + 12'd1;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_data  = data_q;
                resp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// Bench for mem_load_unit: directed loads checked against a byte-level
// big-endian memory model with cycle-exact handshake and latency expectations.
module tb_mem_load_unit;

    localparam int ADDR_LIMIT = 16384;
    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LD = 3'd3;
    localparam logic [2:0] LBU = 3'd4, LHU = 3'd5, LWU = 3'd6, ILL = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = 64'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic        mem_en;
    logic [11:0] mem_waddr;
    logic [31:0] mem_rdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_data;
    logic        resp_err;

    logic [31:0] memw [0:4095];
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_load_unit #(.ADDR_LIMIT(ADDR_LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .mem_en     (mem_en),
        .mem_waddr  (mem_waddr),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    // Memory returns the addressed word one cycle after a strobe, noise otherwise.
    always @(posedge clk) begin
        mem_rdata <= mem_en ? memw[mem_waddr] : $urandom();
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byteAt(input logic [63:0] a);
        logic [31:0] w;
        int k;
        w = memw[a[13:2]];
        k = int'(a[1:0]);
        return w[31 - 8*k -: 8];
    endfunction

    function automatic void modelLoad(input logic [63:0] a, input logic [2:0] f3,
                                      output logic [63:0] d, output logic e, output int lat);
        int size;
        logic [63:0] v;
        size = 1 << f3[1:0];
        e = (f3 == ILL) || ((a % 64'(size)) != 64'd0) || ((a + 64'(size)) > 64'(ADDR_LIMIT));
        d = 64'd0;
        lat = 0;
        if (e) return;
        v = 64'd0;
        for (int i = 0; i < size; i++) begin
            v = (v << 8) | 64'(byteAt(a + 64'(i)));
        end
        if (!f3[2] && size < 8 && v[8*size-1]) begin
            v = v | ~((64'd1 << (8*size)) - 64'd1);
        end
        d = v;
        lat = (size == 8) ? 3 : 2;
    endfunction

    int          cyc = 0;
    int          acceptCyc = 0;
    int          expLat = 0;
    logic        pending = 1'b0;
    logic        expErr = 1'b0;
    logic        expLd = 1'b0;
    logic [63:0] expData = 64'd0;
    logic [63:0] expAddr = 64'd0;
    logic        expValid;
    logic        expMemEn;
    logic [11:0] expWaddr;

    // Cycle-by-cycle comparison against the request most recently accepted.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            checkOutput("reset req_ready", 64'(req_ready), 64'd1);
            checkOutput("reset mem_en", 64'(mem_en), 64'd0);
            checkOutput("reset mem_waddr", 64'(mem_waddr), 64'd0);
            checkOutput("reset resp_valid", 64'(resp_valid), 64'd0);
            checkOutput("reset resp_data", resp_data, 64'd0);
            checkOutput("reset resp_err", 64'(resp_err), 64'd0);
            pending = 1'b0;
        end else begin
            expValid = pending && (cyc >= acceptCyc + 1 + expLat);
            expMemEn = pending && !expErr &&
                       ((cyc == acceptCyc + 1) || (expLd && cyc == acceptCyc + 2));
            expWaddr = expMemEn ? 12'((expAddr >> 2) + 64'(cyc - acceptCyc - 1)) : 12'd0;
            checkOutput("req_ready", 64'(req_ready), 64'(!pending));
            checkOutput("resp_valid", 64'(resp_valid), 64'(expValid));
            checkOutput("mem_en", 64'(mem_en), 64'(expMemEn));
            checkOutput("mem_waddr", 64'(mem_waddr), 64'(expWaddr));
            if (expValid) begin
                checkOutput("resp_data", resp_data, expData);
                checkOutput("resp_err", 64'(resp_err), 64'(expErr));
            end
            if (pending && expValid && resp_ready) begin
                pending = 1'b0;
            end else if (!pending && req_valid) begin
                modelLoad(req_addr, req_funct3, expData, expErr, expLat);
                expAddr   = req_addr;
                expLd     = (req_funct3 == LD) && !expErr;
                acceptCyc = cyc;
                pending   = 1'b1;
            end
        end
    end

    // Called just after a rising edge with the unit idle; returns just after a rising edge, idle again.
    task automatic applyStimulus(input string name, input logic [63:0] a, input logic [2:0] f3,
                                 input int hold, input logic [63:0] expD, input logic expE);
        int n;
        req_valid  = 1'b1;
        req_addr   = a;
        req_funct3 = f3;
        resp_ready = (hold == 0);
        @(posedge clk); #1;
        req_addr   = {$urandom(), $urandom()};
        req_funct3 = 3'($urandom());
        n = 0;
        while (!resp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        if (!resp_valid) begin
            checkOutput({name, " response timeout"}, 64'(resp_valid), 64'd1);
            resp_ready = 1'b1;
            return;
        end
        checkOutput({name, " data"}, resp_data, expD);
        checkOutput({name, " err"}, 64'(resp_err), 64'(expE));
        for (int i = 0; i < hold; i++) begin
            checkOutput({name, " hold req_ready"}, 64'(req_ready), 64'd0);
            checkOutput({name, " hold resp_valid"}, 64'(resp_valid), 64'd1);
            checkOutput({name, " hold resp_data"}, resp_data, expD);
            checkOutput({name, " hold resp_err"}, 64'(resp_err), 64'(expE));
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput({name, " consumed"}, 64'(resp_valid), 64'd0);
        checkOutput({name, " back to idle"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] md;
        logic        me;
        int          ml;

        for (int i = 0; i < 4096; i++) begin
            memw[i] = 32'h9E37_79B9 * 32'(i + 1);
        end
        memw[0]    = 32'h0123_4567;
        memw[2]    = 32'h8899_AABB;
        memw[3]    = 32'hCCDD_EEFF;
        memw[4094] = 32'h1122_3344;
        memw[4095] = 32'h5566_7788;

        modelLoad(64'h9, LB, md, me, ml);
        checkOutput("model LB@0x9", md, 64'hFFFF_FFFF_FFFF_FF99);
        modelLoad(64'h8, LD, md, me, ml);
        checkOutput("model LD@0x8", md, 64'h8899_AABB_CCDD_EEFF);
        checkOutput("model LD latency", 64'(ml), 64'd3);

        // Reset asserted before any clock edge must already force the idle outputs.
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async reset req_ready", 64'(req_ready), 64'd1);
        checkOutput("async reset resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("async reset mem_en", 64'(mem_en), 64'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus("LD@0x8",     64'h8,    LD,  0, 64'h8899_AABB_CCDD_EEFF, 1'b0);
        applyStimulus("LB@0x9",     64'h9,    LB,  0, 64'hFFFF_FFFF_FFFF_FF99, 1'b0);
        applyStimulus("LBU@0x9",    64'h9,    LBU, 0, 64'h99, 1'b0);
        applyStimulus("LH@0xA",     64'hA,    LH,  0, 64'hFFFF_FFFF_FFFF_AABB, 1'b0);
        applyStimulus("LWU@0x8",    64'h8,    LWU, 0, 64'h8899_AABB, 1'b0);
        applyStimulus("LW@0x8",     64'h8,    LW,  0, 64'hFFFF_FFFF_8899_AABB, 1'b0);
        applyStimulus("LHU@0xA",    64'hA,    LHU, 0, 64'hAABB, 1'b0);
        applyStimulus("LH@0x8",     64'h8,    LH,  0, 64'hFFFF_FFFF_FFFF_8899, 1'b0);
        applyStimulus("LB@0x1",     64'h1,    LB,  0, 64'h23, 1'b0);
        applyStimulus("LH@0x2",     64'h2,    LH,  0, 64'h4567, 1'b0);
        applyStimulus("LBU@0xF",    64'hF,    LBU, 0, 64'hFF, 1'b0);
        applyStimulus("LB@0xC",     64'hC,    LB,  0, 64'hFFFF_FFFF_FFFF_FFCC, 1'b0);
        applyStimulus("LW@0x6",     64'h6,    LW,  0, 64'd0, 1'b1);
        applyStimulus("LD@0x4",     64'h4,    LD,  0, 64'd0, 1'b1);
        applyStimulus("ILL@0x0",    64'h0,    ILL, 0, 64'd0, 1'b1);
        applyStimulus("LD@0x3FFC",  64'h3FFC, LD,  0, 64'd0, 1'b1);
        applyStimulus("LW@0x4000",  64'h4000, LW,  0, 64'd0, 1'b1);
        applyStimulus("LH@0x5",     64'h5,    LH,  0, 64'd0, 1'b1);
        applyStimulus("LD@0x3FF8",  64'h3FF8, LD,  0, 64'h1122_3344_5566_7788, 1'b0);
        applyStimulus("LBU@0x3FFF", 64'h3FFF, LBU, 0, 64'h88, 1'b0);
        applyStimulus("LHU@0x3FFE", 64'h3FFE, LHU, 0, 64'h7788, 1'b0);
        applyStimulus("LW@0x0 held", 64'h0,   LW,  5, 64'h0123_4567, 1'b0);
        applyStimulus("LD@0x8 held", 64'h8,   LD,  5, 64'h8899_AABB_CCDD_EEFF, 1'b0);

        // Pulse reset while an LD is in its second read cycle.
        req_valid  = 1'b1;
        req_addr   = 64'h10;
        req_funct3 = LD;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("pre-reset mem_en", 64'(mem_en), 64'd1);
        checkOutput("pre-reset mem_waddr", 64'(mem_waddr), 64'h5);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid-op reset req_ready", 64'(req_ready), 64'd1);
        checkOutput("mid-op reset mem_en", 64'(mem_en), 64'd0);
        checkOutput("mid-op reset mem_waddr", 64'(mem_waddr), 64'd0);
        checkOutput("mid-op reset resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("mid-op reset resp_data", resp_data, 64'd0);
        checkOutput("mid-op reset resp_err", 64'(resp_err), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            checkOutput("no response after reset", 64'(resp_valid), 64'd0);
        end
        applyStimulus("LW@0x0 after reset", 64'h0, LW, 0, 64'h0123_4567, 1'b0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
